// File: rtl/regchk_pkg.sv
// Shared types and width helpers for the register-file checker.
// Optional build macro: REGCHK_MASK_EN (per-register match mask).
package regchk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic int idx_width(input int num_regs);
    return $clog2(num_regs);
  endfunction

  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/regchk_exp_mem.sv
// Expected-value table: one synchronous write port, one asynchronous read port.
// With REGCHK_MASK_EN defined, a parallel 1-bit mask column is added.
module regchk_exp_mem
  import regchk_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REGS   = 32,
  parameter int IDX_W      = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
`ifdef REGCHK_MASK_EN
  ,
  input  logic                  mask_we,
  input  logic [IDX_W-1:0]      mask_waddr,
  input  logic                  mask_wdata,
  output logic                  mask_rdata
`endif
);

  // Table contents survive rst so a test program's expectations outlive a checker abort.
  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

`ifdef REGCHK_MASK_EN
  logic [NUM_REGS-1:0] mask_q;

  always_ff @(posedge clk) begin
    if (mask_we) begin
      mask_q[mask_waddr] <= mask_wdata;
    end
  end

  assign mask_rdata = mask_q[raddr];
`endif

endmodule

// File: rtl/regfile_checker.sv
// Scoreboard for end-of-program register-file state: wait for halt/timeout, scan, report.
// Optional build macro: REGCHK_MASK_EN adds mask_we/mask_waddr/mask_wdata ports.
module regfile_checker
  import regchk_pkg::*;
#(
  parameter int   DATA_WIDTH = 64,
  parameter int   NUM_REGS   = 32,
  parameter int   TIMEOUT    = 1024,
  localparam int  IDX_W      = idx_width(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exp_we,
  input  logic [IDX_W-1:0]      exp_waddr,
  input  logic [DATA_WIDTH-1:0] exp_wdata,
  input  logic                  start,
  input  logic                  core_halt,
  output logic [IDX_W-1:0]      rf_raddr,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timed_out,
  output logic [IDX_W:0]        match_cnt,
  output logic                  mis_valid,
  output logic [IDX_W-1:0]      mis_idx
`ifdef REGCHK_MASK_EN
  ,
  input  logic                  mask_we,
  input  logic [IDX_W-1:0]      mask_waddr,
  input  logic                  mask_wdata
`endif
);

  localparam int               CNT_W    = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W:0]   CNT_ALL  = (IDX_W + 1)'(NUM_REGS);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               timed_out_q, timed_out_d;
  logic [IDX_W:0]     match_cnt_q, match_cnt_d;
  logic               mis_valid_q, mis_valid_d;
  logic [IDX_W-1:0]   mis_idx_q, mis_idx_d;

  logic [DATA_WIDTH-1:0] exp_rdata;
  logic                  masked;
  logic                  hit;

  regchk_exp_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_exp_mem (
    .clk        (clk),
    .we         (exp_we),
    .waddr      (exp_waddr),
    .wdata      (exp_wdata),
    .raddr      (idx_q),
    .rdata      (exp_rdata)
`ifdef REGCHK_MASK_EN
    ,
    .mask_we    (mask_we),
    .mask_waddr (mask_waddr),
    .mask_wdata (mask_wdata),
    .mask_rdata (masked)
`endif
  );

`ifndef REGCHK_MASK_EN
  assign masked = 1'b0;
`endif

  // Table read is asynchronous, so a same-cycle table write is compared against the old entry.
  assign hit = masked | (rf_rdata == exp_rdata);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    timed_out_d = timed_out_q;
    match_cnt_d = match_cnt_q;
    mis_valid_d = mis_valid_q;
    mis_idx_d   = mis_idx_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = WAIT;
          cnt_d       = '0;
          idx_d       = '0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          timed_out_d = 1'b0;
          match_cnt_d = '0;
          mis_valid_d = 1'b0;
          mis_idx_d   = '0;
        end else begin
          state_d = state_q;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Halt wins over a coinciding timeout so timed_out only flags a genuine hang.
        if (core_halt) begin
          state_d     = SCAN;
          timed_out_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = SCAN;
          timed_out_d = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      SCAN: begin
        match_cnt_d = match_cnt_q + {{IDX_W{1'b0}}, hit};
        if (!hit && !mis_valid_q) begin
          mis_valid_d = 1'b1;
          mis_idx_d   = idx_q;
        end else begin
          mis_valid_d = mis_valid_q;
        end
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
          idx_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (match_cnt_d == CNT_ALL);
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timed_out_q <= 1'b0;
      match_cnt_q <= '0;
      mis_valid_q <= 1'b0;
      mis_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timed_out_q <= timed_out_d;
      match_cnt_q <= match_cnt_d;
      mis_valid_q <= mis_valid_d;
      mis_idx_q   <= mis_idx_d;
    end
  end

  assign rf_raddr  = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign timed_out = timed_out_q;
  assign match_cnt = match_cnt_q;
  assign mis_valid = mis_valid_q;
  assign mis_idx   = mis_idx_q;

endmodule

// File: tb/tb_regfile_checker.sv
// Scoreboard bench for regfile_checker: verdicts predicted at start, compared when done rises.
`timescale 1ns/1ps
module tb_regfile_checker;

  localparam int DW = 64;
  localparam int NR = 32;
  localparam int TO = 16;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          exp_we;
  logic [IW-1:0] exp_waddr;
  logic [DW-1:0] exp_wdata;
  logic          start;
  logic          core_halt;
  logic [IW-1:0] rf_raddr;
  logic [DW-1:0] rf_rdata;
  logic          busy, done, pass, timed_out, mis_valid;
  logic [IW:0]   match_cnt;
  logic [IW-1:0] mis_idx;
`ifdef REGCHK_MASK_EN
  logic          mask_we;
  logic [IW-1:0] mask_waddr;
  logic          mask_wdata;
`endif

  logic [DW-1:0] dut_rf    [NR];
  logic [DW-1:0] exp_model [NR];
  logic          mask_model[NR];

  typedef struct {
    logic        pass;
    logic [IW:0] mcnt;
    logic        mv;
    logic [IW-1:0] midx;
    logic        to;
    int          lat;
  } verdict_t;

  verdict_t sb_q[$];
  int total = 0;
  int bad   = 0;

  regfile_checker #(.DATA_WIDTH(DW), .NUM_REGS(NR), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .exp_we     (exp_we),
    .exp_waddr  (exp_waddr),
    .exp_wdata  (exp_wdata),
    .start      (start),
    .core_halt  (core_halt),
    .rf_raddr   (rf_raddr),
    .rf_rdata   (rf_rdata),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .timed_out  (timed_out),
    .match_cnt  (match_cnt),
    .mis_valid  (mis_valid),
    .mis_idx    (mis_idx)
`ifdef REGCHK_MASK_EN
    ,
    .mask_we    (mask_we),
    .mask_waddr (mask_waddr),
    .mask_wdata (mask_wdata)
`endif
  );

  assign rf_rdata = dut_rf[rf_raddr];

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_exp(input int i, input logic [DW-1:0] v);
    @(negedge clk);
    exp_we = 1'b1; exp_waddr = IW'(i); exp_wdata = v;
    @(negedge clk);
    exp_we = 1'b0;
    exp_model[i] = v;
  endtask

  task automatic push_verdict(input int halt_at);
    verdict_t v;
    bit by_halt;
    v.pass = 1'b0; v.mcnt = '0; v.mv = 1'b0; v.midx = '0;
    for (int i = 0; i < NR; i++) begin
      if (mask_model[i] || dut_rf[i] == exp_model[i]) begin
        v.mcnt = v.mcnt + 1'b1;
      end else if (!v.mv) begin
        v.mv = 1'b1; v.midx = IW'(i);
      end
    end
    v.pass  = (v.mcnt == (IW + 1)'(NR));
    by_halt = (halt_at >= 1 && halt_at <= TO);
    v.to    = !by_halt;
    v.lat   = (by_halt ? halt_at : TO) + NR;
    sb_q.push_back(v);
  endtask

  // halt_at: edge (after the start edge) at which core_halt is sampled; 0 = never.
  task automatic run_scan(input int halt_at, input bit rbw, input bit probe, input bit rst_at10);
    int cycles;
    bit rbw_hit;
    verdict_t v;
    rbw_hit = 1'b0;
    @(negedge clk);
    start = 1'b1;
    push_verdict(halt_at);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    check_val("armed", 64'({busy, done, pass, timed_out, mis_valid, match_cnt, mis_idx}),
              64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 5'd0}));
    while (cycles < 200 && !done) begin
      if (rst_at10 && busy && rf_raddr == 5'd10) break;
      core_halt = (halt_at > 0 && cycles == halt_at - 1);
      start     = (probe && cycles == 2);
      if (rbw && busy && rf_raddr == 5'd12 && !rbw_hit) begin
        exp_we = 1'b1; exp_waddr = 5'd12; exp_wdata = ~exp_model[12];
        rbw_hit = 1'b1;
      end else begin
        exp_we = 1'b0;
      end
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
    core_halt = 1'b0; start = 1'b0; exp_we = 1'b0;
    if (rbw_hit) exp_model[12] = ~exp_model[12];
    if (rst_at10) begin
      check_val("rst_reach_idx10", 64'(rf_raddr), 64'd10);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_val("rst_abort_outs",
                64'({busy, done, pass, timed_out, mis_valid, match_cnt, mis_idx, rf_raddr}), 64'd0);
      void'(sb_q.pop_back());
      return;
    end
    v = sb_q.pop_front();
    if (!done) begin
      check_val("done_within_bound", 64'(done), 64'd1);
      return;
    end
    check_val("latency",   64'(cycles),    64'(v.lat));
    check_val("pass",      64'(pass),      64'(v.pass));
    check_val("match_cnt", 64'(match_cnt), 64'(v.mcnt));
    check_val("mis_valid", 64'(mis_valid), 64'(v.mv));
    check_val("mis_idx",   64'(mis_idx),   64'(v.midx));
    check_val("timed_out", 64'(timed_out), 64'(v.to));
    check_val("busy_off",  64'(busy),      64'd0);
    @(posedge clk);
    @(negedge clk);
    check_val("done_held", 64'({done, pass}), 64'({1'b1, v.pass}));
  endtask

  initial begin
    rst = 1'b1; exp_we = 1'b0; exp_waddr = '0; exp_wdata = '0;
    start = 1'b0; core_halt = 1'b0;
`ifdef REGCHK_MASK_EN
    mask_we = 1'b0; mask_waddr = '0; mask_wdata = 1'b0;
`endif
    for (int i = 0; i < NR; i++) begin
      mask_model[i] = 1'b0;
      dut_rf[i]     = 64'(i) * 64'h11;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_outs",
              64'({busy, done, pass, timed_out, mis_valid, match_cnt, mis_idx, rf_raddr}), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < NR; i++) write_exp(i, 64'(i) * 64'h11);
`ifdef REGCHK_MASK_EN
    for (int i = 0; i < NR; i++) begin
      @(negedge clk);
      mask_we = 1'b1; mask_waddr = IW'(i); mask_wdata = 1'b0;
    end
    @(negedge clk);
    mask_we = 1'b0;
`endif
    check_val("idle_no_done", 64'({busy, done}), 64'd0);

    // All registers match, halt sampled 5 edges after start.
    run_scan(5, 1'b0, 1'b0, 1'b0);

    // Regs 7 and 20 wrong; stray start in WAIT ignored; exp[12] rewritten while compared.
    dut_rf[7]  = dut_rf[7] ^ 64'h1;
    dut_rf[20] = dut_rf[20] ^ 64'hF000_0000_0000_0000;
    run_scan(5, 1'b1, 1'b1, 1'b0);
    write_exp(12, 64'd12 * 64'h11);
    dut_rf[7]  = 64'd7 * 64'h11;
    dut_rf[20] = 64'd20 * 64'h11;

    // No halt: timeout after TO cycles; then halt coinciding with the timeout cycle.
    run_scan(0, 1'b0, 1'b0, 1'b0);
    run_scan(TO, 1'b0, 1'b0, 1'b0);
    run_scan(1, 1'b0, 1'b0, 1'b0);

    // Reset mid-scan, then a fresh full scan with a mismatch at the last register.
    run_scan(5, 1'b0, 1'b0, 1'b1);
    dut_rf[31] = ~dut_rf[31];
    run_scan(3, 1'b0, 1'b0, 1'b0);
    dut_rf[31] = 64'd31 * 64'h11;

    // Reg 2 wrong: masked out when the mask feature is built in.
    dut_rf[2] = 64'hDEAD_BEEF;
`ifdef REGCHK_MASK_EN
    @(negedge clk);
    mask_we = 1'b1; mask_waddr = 5'd2; mask_wdata = 1'b1;
    @(negedge clk);
    mask_we = 1'b0;
    mask_model[2] = 1'b1;
`endif
    run_scan(5, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
